// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce plus run/pause/lap sequencer driving tick, clear and freeze.
// Defining LAP_COUNT_EN adds a 0..9 lap counter output (lap_count).

module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level, level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      press   <= level & ~level_q;
      // any sample matching the accepted level restarts the stability window
      if (sync[1] == level)
        cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PRE_W           = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       tick,
  output logic       clear,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
`ifdef LAP_COUNT_EN
  ,
  output logic [3:0] lap_count
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, LAP = 2'd2, PAUSED = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [1:0]       btn, press;
  logic             ss, lr, clear_d, freeze_d, run_st, pre_term;
  logic [PRE_W-1:0] pre;

  assign btn = {btn_lap_reset, btn_start_stop};

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
    .clock(clock), .reset(reset), .raw(btn), .press(press)
  );

  // start_stop wins a same-cycle collision
  assign ss       = press[0];
  assign lr       = press[1] & ~press[0];
  assign run_st   = (state_q == RUNNING) || (state_q == LAP);
  assign pre_term = run_st && (pre == PRE_W'(TICK_DIV - 1));
  assign state    = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick    <= 1'b0;
      clear   <= 1'b0;
      freeze  <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      tick    <= pre_term;
      clear   <= clear_d;
      freeze  <= freeze_d;
      running <= (state_d == RUNNING) || (state_d == LAP);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss) state_d = RUNNING;
      RUNNING: if (ss) state_d = PAUSED; else if (lr) state_d = LAP;
      LAP:     if (ss) state_d = PAUSED; else if (lr) state_d = RUNNING;
      PAUSED:  if (ss) state_d = RUNNING; else if (lr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_d  = 1'b0;
    freeze_d = freeze;
    case (state_q)
      IDLE:    if (lr) clear_d = 1'b1;
      RUNNING: if (lr) freeze_d = 1'b1;
      LAP:     if (ss || lr) freeze_d = 1'b0;
      PAUSED:  if (lr) clear_d = 1'b1;
      default: freeze_d = 1'b0;
    endcase
  end

  // PAUSED holds the count so a resume continues the partial second
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pre <= '0;
    else if (pre_term)
      pre <= '0;
    else if (run_st)
      pre <= pre + 1'b1;
    else if (state_q == IDLE || (state_q == PAUSED && lr))
      pre <= '0;
  end

`ifdef LAP_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      lap_count <= 4'd0;
    else if (clear_d)
      lap_count <= 4'd0;
    else if (state_q == RUNNING && state_d == LAP)
      lap_count <= (lap_count == 4'd9) ? 4'd0 : lap_count + 4'd1;
  end
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: cycle model of the button/FSM rules compared every cycle,
// plus directed scenarios with hand-computed latencies and counts.
module tb_stopwatch_ctrl;
  localparam int TD = 10;
  localparam int DB = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3;

  logic       clock, reset, bss, blr;
  logic       tick, clear, freeze, running;
  logic [1:0] state;
`ifdef LAP_COUNT_EN
  logic [3:0] lap_count;
`endif

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .PRE_W(26)) dut (
    .clock(clock), .reset(reset),
    .btn_start_stop(bss), .btn_lap_reset(blr),
    .tick(tick), .clear(clear), .freeze(freeze), .running(running),
    .state(state)
`ifdef LAP_COUNT_EN
    , .lap_count(lap_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;
  int tick_cnt, clear_cnt, chg_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {state, running, freeze, clear, tick};
  endfunction

  // ---------------- reference model ----------------
  int m_state, m_pre, m_lap;
  bit m_tick, m_clear, m_ss, m_lr, m_run;
  int ns;
  bit r1[2], r2[2], lvl[2], rose[2], pv[2], smp;
  int dcnt[2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state = S_IDLE; m_pre = 0; m_lap = 0; m_tick = 0; m_clear = 0;
      for (int b = 0; b < 2; b++) begin
        r1[b] = 0; r2[b] = 0; lvl[b] = 0; rose[b] = 0; pv[b] = 0; dcnt[b] = 0;
      end
    end else begin
      m_ss = pv[0];
      m_lr = pv[1] && !pv[0];
      m_run = (m_state == S_RUN) || (m_state == S_LAP);
      m_tick = m_run && (m_pre == TD - 1);
      if (m_run) m_pre = (m_pre + 1) % TD;
      else if (m_state == S_IDLE) m_pre = 0;
      ns = m_state; m_clear = 0;
      case (m_state)
        S_IDLE:  if (m_ss) ns = S_RUN; else if (m_lr) m_clear = 1;
        S_RUN:   if (m_ss) ns = S_PAUSE; else if (m_lr) ns = S_LAP;
        S_LAP:   if (m_ss) ns = S_PAUSE; else if (m_lr) ns = S_RUN;
        default: if (m_ss) ns = S_RUN; else if (m_lr) begin ns = S_IDLE; m_clear = 1; m_pre = 0; end
      endcase
      if (m_state == S_RUN && ns == S_LAP) m_lap = (m_lap + 1) % 10;
      if (m_clear) m_lap = 0;
      m_state = ns;
      // button: sample two edges old; level flips after DB consecutive differing samples
      for (int b = 0; b < 2; b++) begin
        pv[b] = rose[b];
        rose[b] = 0;
        smp = r2[b];
        if (smp != lvl[b]) dcnt[b]++; else dcnt[b] = 0;
        if (dcnt[b] == DB) begin
          lvl[b] = smp; dcnt[b] = 0; rose[b] = smp;
        end
        r2[b] = r1[b];
        r1[b] = (b == 0) ? bss : blr;
      end
    end
  end

  always @(negedge clock) begin
    logic [5:0] exp_o;
    exp_o = {m_state[1:0], (m_state == S_RUN || m_state == S_LAP), (m_state == S_LAP), m_clear, m_tick};
    n_vec++;
    if (outs() !== exp_o) begin
      n_err++;
      $display("FAIL cycle_outs: got %b expected %b (state,run,frz,clr,tick) at %0t", outs(), exp_o, $time);
    end
`ifdef LAP_COUNT_EN
    n_vec++;
    if (lap_count !== 4'(m_lap)) begin
      n_err++;
      $display("FAIL cycle_lap: got %0d expected %0d at %0t", lap_count, m_lap, $time);
    end
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_cycles(input int n);
    logic [1:0] p;
    for (int i = 0; i < n; i++) begin
      p = state;
      @(negedge clock);
      if (state != p) chg_cnt++;
      tick_cnt += int'(tick);
      clear_cnt += int'(clear);
    end
  endtask

  task automatic clr_cnts();
    tick_cnt = 0; clear_cnt = 0; chg_cnt = 0;
  endtask

  task automatic press_btn(input int idx);
    if (idx == 0) bss = 1'b1; else blr = 1'b1;
    run_cycles(10);
    bss = 1'b0; blr = 1'b0;
    run_cycles(10);
  endtask

  task automatic wait_tick(output int n, input int limit);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic wait_state(input logic [1:0] v, output int n, input int limit);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (state != v && n < limit);
  endtask

  initial begin
    int n;
    reset = 1'b1; bss = 1'b0; blr = 1'b0;
    clr_cnts();
    repeat (3) @(negedge clock);
    chk("reset_outs", int'(outs()), 0);
    reset = 1'b0;

    // idle
    run_cycles(50);
    chk("idle_state", int'(state), 0);
    chk("idle_activity", tick_cnt + clear_cnt + chg_cnt, 0);

    // clean start press: state changes 8 edges after the raw edge
    bss = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 7) chk("ss_lat_before", int'(state), 0);
      if (i == 8) chk("ss_lat_after", int'(state), 1);
    end
    bss = 1'b0;
    wait_tick(n, 20);
    chk("first_tick", n, 8);
    wait_tick(n, 20);
    chk("tick_period", n, 10);

    // bouncing press from RUNNING: one press only
    clr_cnts();
    for (int i = 0; i < 6; i++) begin
      bss = (i % 2 == 0);
      run_cycles(1);
    end
    chk("bounce_quiet", chg_cnt, 0);
    bss = 1'b1;
    run_cycles(10);
    bss = 1'b0;
    run_cycles(12);
    chk("bounce_one_press", chg_cnt, 1);
    chk("bounce_paused", int'(state), 3);

    press_btn(0);
    chk("resume_run", int'(state), 1);

    // lap hold
    press_btn(1);
    chk("lap_state", int'(state), 2);
    chk("lap_freeze", int'(freeze), 1);
    clr_cnts();
    run_cycles(30);
    chk("lap_ticks", tick_cnt, 3);
    press_btn(1);
    chk("unlap_state", int'(state), 1);
    chk("unlap_freeze", int'(freeze), 0);

    // pause with prescaler held at 6, resume -> tick after 4 cycles
    wait_tick(n, 12);
    repeat (8) @(negedge clock);
    bss = 1'b1;
    repeat (10) @(negedge clock);
    bss = 1'b0;
    chk("pause_state", int'(state), 3);
    clr_cnts();
    run_cycles(30);
    chk("pause_no_tick", tick_cnt, 0);
    bss = 1'b1;
    wait_state(2'd1, n, 15);
    chk("resume_lat", n, 8);
    bss = 1'b0;
    wait_tick(n, 20);
    chk("resume_tick", n, 4);
    run_cycles(12);

    // pause then lap_reset -> IDLE with a single clear
    press_btn(0);
    chk("pause2_state", int'(state), 3);
    clr_cnts();
    press_btn(1);
    chk("clear_once", clear_cnt, 1);
    chk("to_idle", int'(state), 0);

    // simultaneous presses from IDLE: start wins
    clr_cnts();
    bss = 1'b1; blr = 1'b1;
    run_cycles(10);
    bss = 1'b0; blr = 1'b0;
    run_cycles(10);
    chk("simul_state", int'(state), 1);
    chk("simul_no_clear", clear_cnt, 0);

`ifdef LAP_COUNT_EN
    for (int i = 0; i < 11; i++) begin
      press_btn(1);
      press_btn(1);
    end
    chk("lap_count_11", int'(lap_count), 1);
`endif

    // async reset mid-LAP
    press_btn(1);
    chk("prereset_lap", int'(state), 2);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk("async_reset_outs", int'(outs()), 0);
`ifdef LAP_COUNT_EN
    chk("async_reset_lap", int'(lap_count), 0);
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    clr_cnts();
    run_cycles(20);
    chk("post_reset_idle", int'(state), 0);
    chk("post_reset_quiet", tick_cnt + clear_cnt + chg_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
